// File: rtl/lsm_sequencer.sv
// lsm_sequencer: Load/Store-Multiple sequencer beside the microprogrammed
// control unit. Walks the IR register list in ascending order, supplying the
// register number and memory address of each transfer plus the Rn write-back
// value, and flags pending/last transfer for microbranching.
//
// Ports:
//   CLK, RESET      clock (rising edge), synchronous active-high reset
//   LSM_EN, LSM_IN  command strobe and command (HOLD/LOAD/NEXT/CLEAR, 1xx = HOLD)
//   REG_LIST, PU    IR[15:0] register list, IR[24:23] {P,U}
//   BASE            base register value Rn
//   LSM_DETECT      a transfer is pending
//   LSM_END         current transfer is the last one, or sequence finished
//   REG_NUM, ADDR   register number / memory address of the current transfer
//   WB_ADDR         Rn write-back value
//   COUNT           transfers remaining, including the current one
module lsm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int LIST_W = 16,
    parameter int STEP   = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      LSM_EN,
    input  logic [2:0]                LSM_IN,
    input  logic [LIST_W-1:0]         REG_LIST,
    input  logic [1:0]                PU,
    input  logic [ADDR_W-1:0]         BASE,
    output logic                      LSM_DETECT,
    output logic                      LSM_END,
    output logic [$clog2(LIST_W)-1:0] REG_NUM,
    output logic [ADDR_W-1:0]         ADDR,
    output logic [ADDR_W-1:0]         WB_ADDR,
    output logic [$clog2(LIST_W):0]   COUNT
);

    localparam int RN_W  = $clog2(LIST_W);
    localparam int CNT_W = RN_W + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t              state, state_nx;
    logic [LIST_W-1:0]   pending, pending_nx;
    logic [ADDR_W-1:0]   addr, addr_nx;
    logic [ADDR_W-1:0]   wb_addr, wb_addr_nx;
    logic [CNT_W-1:0]    count, count_nx;

    logic [CNT_W-1:0]    n;
    logic [ADDR_W-1:0]   span;
    logic [LIST_W-1:0]   pending_dec;
    logic                found;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            pending <= '0;
            addr    <= '0;
            wb_addr <= '0;
            count   <= '0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            addr    <= addr_nx;
            wb_addr <= wb_addr_nx;
            count   <= count_nx;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        n = '0;
        for (int unsigned i = 0; i < LIST_W; i++) begin
            n = n + CNT_W'(REG_LIST[i]);
        end
        span        = ADDR_W'(n) * ADDR_W'(STEP);
        pending_dec = pending & (pending - LIST_W'(1));

        state_nx   = state;
        pending_nx = pending;
        addr_nx    = addr;
        wb_addr_nx = wb_addr;
        count_nx   = count;

        if (LSM_EN && !LSM_IN[2]) begin
            case (LSM_IN[1:0])
                2'b01: begin
                    pending_nx = REG_LIST;
                    count_nx   = n;
                    if (n == '0) begin
                        state_nx   = DONE;
                        addr_nx    = BASE;
                        wb_addr_nx = BASE;
                    end else begin
                        state_nx = ACTIVE;
                        case (PU)
                            2'b01: begin addr_nx = BASE;                       wb_addr_nx = BASE + span; end
                            2'b11: begin addr_nx = BASE + ADDR_W'(STEP);       wb_addr_nx = BASE + span; end
                            2'b00: begin addr_nx = BASE - span + ADDR_W'(STEP); wb_addr_nx = BASE - span; end
                            default: begin addr_nx = BASE - span;              wb_addr_nx = BASE - span; end
                        endcase
                    end
                end
                2'b10: begin
                    if (state == ACTIVE) begin
                        pending_nx = pending_dec;
                        count_nx   = count - CNT_W'(1);
                        // Address freezes on the final transfer so DONE still shows it
                        if (pending_dec == '0) begin
                            state_nx = DONE;
                        end else begin
                            addr_nx = addr + ADDR_W'(STEP);
                        end
                    end
                end
                2'b11: begin
                    state_nx   = IDLE;
                    pending_nx = '0;
                    addr_nx    = '0;
                    wb_addr_nx = '0;
                    count_nx   = '0;
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        REG_NUM = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < LIST_W; i++) begin
            if (pending[i] && !found) begin
                REG_NUM = RN_W'(i);
                found   = 1'b1;
            end
        end
        LSM_DETECT = (state == ACTIVE);
        LSM_END    = ((state == ACTIVE) && (count == CNT_W'(1))) || (state == DONE);
        ADDR       = addr;
        WB_ADDR    = wb_addr;
        COUNT      = count;
    end

endmodule

// File: tb/tb_lsm_sequencer.sv
// tb_lsm_sequencer: directed scoreboard bench for lsm_sequencer.
module tb_lsm_sequencer;

    localparam logic [2:0] HOLD  = 3'b000;
    localparam logic [2:0] LOAD  = 3'b001;
    localparam logic [2:0] NEXT  = 3'b010;
    localparam logic [2:0] CLEAR = 3'b011;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        LSM_EN = 1'b0;
    logic [2:0]  LSM_IN = HOLD;
    logic [15:0] REG_LIST = '0;
    logic [1:0]  PU = '0;
    logic [31:0] BASE = '0;
    logic        LSM_DETECT;
    logic        LSM_END;
    logic [3:0]  REG_NUM;
    logic [31:0] ADDR;
    logic [31:0] WB_ADDR;
    logic [4:0]  COUNT;

    typedef struct {
        string       tag;
        logic        det;
        logic        fin;
        logic [3:0]  rn;
        logic [31:0] addr;
        logic [31:0] wb;
        logic [4:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    lsm_sequencer #(.ADDR_W(32), .LIST_W(16), .STEP(4)) dut (
        .CLK(CLK), .RESET(RESET), .LSM_EN(LSM_EN), .LSM_IN(LSM_IN),
        .REG_LIST(REG_LIST), .PU(PU), .BASE(BASE),
        .LSM_DETECT(LSM_DETECT), .LSM_END(LSM_END), .REG_NUM(REG_NUM),
        .ADDR(ADDR), .WB_ADDR(WB_ADDR), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %h expected %h", tag, field, obs, exp);
        end
    endtask

    // Drive one command, record the expectation, compare it one edge later.
    task automatic step(input string tag, input logic rst, input logic en, input logic [2:0] cmd,
                        input logic det, input logic fin, input logic [3:0] rn,
                        input logic [31:0] a, input logic [31:0] wb, input logic [4:0] cnt);
        exp_t e;
        exp_t got;
        RESET  = rst;
        LSM_EN = en;
        LSM_IN = cmd;
        e.tag = tag; e.det = det; e.fin = fin; e.rn = rn; e.addr = a; e.wb = wb; e.cnt = cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        check(got.tag, "detect", 32'(LSM_DETECT), 32'(got.det));
        check(got.tag, "end",    32'(LSM_END),    32'(got.fin));
        check(got.tag, "regnum", 32'(REG_NUM),    32'(got.rn));
        check(got.tag, "addr",   ADDR,            got.addr);
        check(got.tag, "wb",     WB_ADDR,         got.wb);
        check(got.tag, "count",  32'(COUNT),      32'(got.cnt));
        RESET  = 1'b0;
        LSM_EN = 1'b0;
        LSM_IN = HOLD;
    endtask

    initial begin
        @(posedge CLK); #1;
        step("reset",      1, 0, HOLD, 0, 0, 0, 32'h0, 32'h0, 0);
        step("next_idle",  0, 1, NEXT, 0, 0, 0, 32'h0, 32'h0, 0);

        // IA
        BASE = 32'h1000; PU = 2'b01; REG_LIST = 16'h000D;
        step("ia_load",    0, 1, LOAD, 1, 0, 0, 32'h1000, 32'h100C, 3);
        step("ia_next1",   0, 1, NEXT, 1, 0, 2, 32'h1004, 32'h100C, 2);
        step("hold_en0a",  0, 0, NEXT, 1, 0, 2, 32'h1004, 32'h100C, 2);
        step("hold_en0b",  0, 0, NEXT, 1, 0, 2, 32'h1004, 32'h100C, 2);
        step("hold_en0c",  0, 0, NEXT, 1, 0, 2, 32'h1004, 32'h100C, 2);
        step("rsvd_100",   0, 1, 3'b100, 1, 0, 2, 32'h1004, 32'h100C, 2);
        step("rsvd_111",   0, 1, 3'b111, 1, 0, 2, 32'h1004, 32'h100C, 2);
        step("ia_next2",   0, 1, NEXT, 1, 1, 3, 32'h1008, 32'h100C, 1);
        step("ia_done",    0, 1, NEXT, 0, 1, 0, 32'h1008, 32'h100C, 0);
        step("next_done",  0, 1, NEXT, 0, 1, 0, 32'h1008, 32'h100C, 0);

        // DB
        BASE = 32'h2000; PU = 2'b10; REG_LIST = 16'h8001;
        step("db_load",    0, 1, LOAD, 1, 0, 0,  32'h1FF8, 32'h1FF8, 2);
        step("db_next",    0, 1, NEXT, 1, 1, 15, 32'h1FFC, 32'h1FF8, 1);
        step("db_done",    0, 1, NEXT, 0, 1, 0,  32'h1FFC, 32'h1FF8, 0);

        // IB, then DA loaded while ACTIVE
        BASE = 32'h1000; PU = 2'b11;
        step("ib_load",    0, 1, LOAD, 1, 0, 0,  32'h1004, 32'h1008, 2);
        BASE = 32'h2000; PU = 2'b00;
        step("da_load",    0, 1, LOAD, 1, 0, 0,  32'h1FFC, 32'h1FF8, 2);
        step("da_next",    0, 1, NEXT, 1, 1, 15, 32'h2000, 32'h1FF8, 1);

        // Restart mid-sequence with a new list
        BASE = 32'h500; PU = 2'b01; REG_LIST = 16'h0030;
        step("restart",    0, 1, LOAD, 1, 0, 4, 32'h500, 32'h508, 2);
        step("rst_w_next", 1, 1, NEXT, 0, 0, 0, 32'h0, 32'h0, 0);

        // Single-register list and CLEAR
        BASE = 32'h10; REG_LIST = 16'h0002;
        step("one_load",   0, 1, LOAD,  1, 1, 1, 32'h10, 32'h14, 1);
        step("clear",      0, 1, CLEAR, 0, 0, 0, 32'h0, 32'h0, 0);

        // Empty list
        BASE = 32'h40; PU = 2'b11; REG_LIST = 16'h0000;
        step("empty",      0, 1, LOAD, 0, 1, 0, 32'h40, 32'h40, 0);

        // Wrap
        BASE = 32'hFFFF_FFFC; PU = 2'b01; REG_LIST = 16'h0003;
        step("wrap_load",  0, 1, LOAD, 1, 0, 0, 32'hFFFF_FFFC, 32'h4, 2);
        step("wrap_next",  0, 1, NEXT, 1, 1, 1, 32'h0, 32'h4, 1);
        step("wrap_done",  0, 1, NEXT, 0, 1, 0, 32'h0, 32'h4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Load/Store-Multiple sequencer for the ARM datapath; sits directly beside the microprogrammed control unit.
- Consumes the control unit's LSM_EN and LSM_IN[2:0] control-word fields, plus the register list, P/U bits and base address from IR and the register file.
- Produces LSM_DETECT and LSM_END, which the control unit uses for microbranching.
- Supplies the current transfer register number and memory address to the datapath, and the final base value for write-back.

Parameters:
- ADDR_W, 32: address/base width; all address arithmetic is modulo 2^ADDR_W.
- LIST_W, 16: register-list width; REG_NUM width = log2(LIST_W) = 4.
- STEP, 4: bytes per transferred word.

Ports:
- CLK  in  1: clock; rising edge.
- RESET  in  1: synchronous, active-high reset.
- LSM_EN  in  1: command strobe from the control word; when 0 the block holds all state.
- LSM_IN  in  3: command. 000 HOLD, 001 LOAD, 010 NEXT, 011 CLEAR, 1xx reserved (treated as HOLD).
- REG_LIST  in  16: IR[15:0]; bit i set means register Ri is transferred.
- PU  in  2: {P,U} = IR[24:23].
- BASE  in  32: base register value Rn.
- LSM_DETECT  out  1: a transfer is pending (state ACTIVE).
- LSM_END  out  1: the current transfer is the last one, or the sequence is finished.
- REG_NUM  out  4: register number of the current transfer.
- ADDR  out  32: memory address of the current transfer.
- WB_ADDR  out  32: Rn write-back value.
- COUNT  out  5: transfers remaining, including the current one.

Behaviour:
- State machine: IDLE, ACTIVE, DONE. Commands act only on a rising CLK edge with LSM_EN=1. All outputs derive from registered state; there is no combinational path from any input to any output.
- Reset: RESET=1 at an edge forces IDLE and zeroes the pending list, ADDR, WB_ADDR and COUNT. This applies from any state, mid-sequence included, and overrides any command on the same edge. In IDLE all outputs are 0.
- Address calculation at LOAD, with n = popcount(REG_LIST):
  - IA (P=0, U=1): start = BASE; WB = BASE + 4n.
  - IB (P=1, U=1): start = BASE + 4; WB = BASE + 4n.
  - DA (P=0, U=0): start = BASE - 4n + 4; WB = BASE - 4n.
  - DB (P=1, U=0): start = BASE - 4n; WB = BASE - 4n.
  - Registers always transfer in ascending register order at ascending addresses.
- LOAD, in any state:
  - Latches pending = REG_LIST, ADDR = start, WB_ADDR = WB, COUNT = n.
  - Next state is ACTIVE if n > 0; otherwise DONE with ADDR = WB_ADDR = BASE.
  - LOAD while ACTIVE aborts the current sequence and restarts.
- NEXT in ACTIVE:
  - Clears the lowest set bit of pending, ADDR += 4, COUNT -= 1.
  - If pending becomes 0, next state is DONE and ADDR/WB_ADDR are held.
  - NEXT in IDLE or DONE is ignored.
- CLEAR: next state IDLE; ADDR, WB_ADDR, COUNT and pending are zeroed.
- Output decode:
  - REG_NUM = index of the lowest set bit of pending; 0 when pending = 0.
  - LSM_DETECT = (state == ACTIVE).
  - LSM_END = (ACTIVE and COUNT == 1) or (state == DONE).
- Latency: outputs reflect a command one edge after it is sampled. The control unit can issue NEXT on consecutive cycles.
- Address wrap: increments and decrements wrap modulo 2^32 with no flag.
- Simultaneous events: RESET beats LSM_EN. With LSM_EN=0, nothing changes regardless of LSM_IN.

Test Plan:
- IA: BASE=0x1000, PU=01, LIST=0x000D, LOAD -> DETECT=1, REG_NUM=0, ADDR=0x1000, WB=0x100C, COUNT=3, END=0. NEXT -> REG_NUM=2, ADDR=0x1004. NEXT -> REG_NUM=3, ADDR=0x1008, END=1. NEXT -> DONE, DETECT=0, END=1, COUNT=0.
- DB: BASE=0x2000, PU=10, LIST=0x8001, LOAD -> REG_NUM=0, ADDR=0x1FF8, WB=0x1FF8. NEXT -> REG_NUM=15, ADDR=0x1FFC, END=1. IB/DA with the same list -> start 0x1004/0x1FFC, WB 0x1008/0x1FF8.
- Empty list: LOAD with LIST=0x0000, BASE=0x40 -> DONE on the next edge; DETECT=0, END=1, COUNT=0, WB=0x40.
- Hold and ignore:
  - LSM_EN=0 with LSM_IN=010 for 3 cycles mid-sequence -> no output change.
  - LSM_IN=1xx -> no change.
  - NEXT in IDLE -> outputs stay 0.
- Reset/restart:
  - RESET=1 together with NEXT while ACTIVE -> IDLE, all outputs 0 after that edge.
  - LOAD while ACTIVE with a new list -> restarts with the new REG_NUM, ADDR and COUNT.
- Wrap: BASE=0xFFFFFFFC, PU=01, LIST=0x0003 -> ADDR 0xFFFFFFFC then 0x00000000; WB=0x00000004.
